// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the shared data-memory port.
// The arbiter takes the slave view; the bench, acting as requesters and memory, takes the master view.
interface mem_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_we;
    logic                    mem_re;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport master (
        output req, we, lock, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency memory port among N_REQ requesters,
// with lockable bursts capped at MAX_BURST and tagged read returns.
module mem_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 10,
    parameter int MAX_BURST = 8
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [N_REQ-1:0]   rtag_q, rtag_d;
    logic [N_REQ-1:0]   rvalid_q;
    logic [N_REQ-1:0]   gnt;
    logic               grantValid;
    logic [PTR_W-1:0]   grantIdx;
    logic               keepOwner;
    int                 idx;

    // Owner keeps the port while it requests, holds lock and has burst budget left;
    // otherwise fall back to a round-robin search starting at ptr in the same cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        grantValid  = 1'b0;
        grantIdx    = ptr_q;
        idx         = 0;
        keepOwner   = (state_q == OWNED) && bus.req[owner_q] && bus.lock[owner_q]
                      && (burst_cnt_q < CNT_W'(MAX_BURST));

        if (!rst) begin
            if (keepOwner) begin
                grantValid  = 1'b1;
                grantIdx    = owner_q;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (int'(ptr_q) + k) % N_REQ;
                    if (!grantValid && bus.req[idx]) begin
                        grantValid = 1'b1;
                        grantIdx   = PTR_W'(idx);
                    end
                end
                if (grantValid && bus.lock[grantIdx]) begin
                    state_d     = OWNED;
                    owner_d     = grantIdx;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            if (grantValid) begin
                gnt[grantIdx] = 1'b1;
                ptr_d = (grantIdx == PTR_W'(N_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
            end
        end
    end

    // Address and write data hold their last value on idle cycles.
    always_comb begin
        mem_we_d    = grantValid & bus.we[grantIdx];
        mem_re_d    = grantValid & ~bus.we[grantIdx];
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grantValid) begin
            mem_addr_d  = bus.addr[grantIdx*ADDR_W +: ADDR_W];
            mem_wdata_d = bus.wdata[grantIdx*DATA_W +: DATA_W];
        end
        rtag_d = mem_re_d ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rtag_q      <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rtag_q      <= rtag_d;
            rvalid_q    <= rtag_q;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors for arbitration,
// bursts and reset, plus a hand-written write-then-read sequence checked against a memory model.
module tb_mem_port_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory with one cycle of read latency.
    logic [DATA_W-1:0] memArr [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] memRdata;
    always @(posedge clk) begin
        if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) memRdata <= memArr[bus.mem_addr];
    end
    assign bus.mem_rdata = memRdata;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] expGnt;
        logic       expRe;
        logic [3:0] expRv;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                          input logic [3:0] g, input logic re, input logic [3:0] rv);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.expGnt = g; v.expRe = re; v.expRv = rv;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] w,
                                 input logic [3:0] lk);
        rst      = r;
        bus.req  = rq;
        bus.we   = w;
        bus.lock = lk;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int a = 0; a < (1 << ADDR_W); a++) memArr[a] = '0;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < N_REQ; i++) begin
            bus.addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(14'h100 + i);
            bus.wdata[i*DATA_W +: DATA_W] = DATA_W'(i);
        end

        //     rst   req      lock     gnt      re    rvalid
        addVec(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1, 4'b0000);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1, 4'b0001);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 4'b0010);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0100);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1, 4'b1000);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1, 4'b0001);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 4'b0010);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        // Pointer wrap: grant 2 leaves ptr=3, lone req[3] wraps ptr to 0.
        addVec(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b0000);
        addVec(1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b1, 4'b0100);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1000);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001);
        // Locked burst of 8 for requester 1 with requester 3 waiting.
        addVec(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b0000);
        for (int i = 0; i < 6; i++)
            addVec(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b0010);
        addVec(1'b0, 4'b1010, 4'b0010, 4'b1000, 1'b1, 4'b0010);
        addVec(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b0010);
        addVec(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b1000);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0010);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        // Requester 0 locked for 3 grants, drops lock with requester 2 waiting; ptr then 3.
        addVec(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000);
        addVec(1'b0, 4'b0101, 4'b0001, 4'b0001, 1'b1, 4'b0000);
        addVec(1'b0, 4'b0101, 4'b0001, 4'b0001, 1'b1, 4'b0001);
        addVec(1'b0, 4'b0101, 4'b0000, 4'b0100, 1'b1, 4'b0001);
        addVec(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, 4'b0001);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000);
        // Reset one cycle after a read grant drops the read; ptr restarts at 0.
        addVec(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b0000);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("reset mem_wdata", 32'(bus.mem_wdata), 32'h0);

        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[n].rst, vecs[n].req, 4'b0000, vecs[n].lock);
            @(negedge clk);
            checkOutput($sformatf("v%0d gnt", n), 32'(bus.gnt), 32'(vecs[n].expGnt));
            checkOutput($sformatf("v%0d mem_re", n), 32'(bus.mem_re), 32'(vecs[n].expRe));
            checkOutput($sformatf("v%0d mem_we", n), 32'(bus.mem_we), 32'h0);
            checkOutput($sformatf("v%0d rvalid", n), 32'(bus.rvalid), 32'(vecs[n].expRv));
        end

        // Requester 2 writes 0x2A5 to 0x0005, requester 0 reads it back next cycle.
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000);
        bus.addr[2*ADDR_W +: ADDR_W]  = 14'h0005;
        bus.wdata[2*DATA_W +: DATA_W] = 10'h2A5;
        @(negedge clk);
        checkOutput("wr gnt", 32'(bus.gnt), 32'h4);

        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus.addr[0*ADDR_W +: ADDR_W] = 14'h0005;
        @(negedge clk);
        checkOutput("rd gnt", 32'(bus.gnt), 32'h1);
        checkOutput("wr mem_we", 32'(bus.mem_we), 32'h1);
        checkOutput("wr mem_re", 32'(bus.mem_re), 32'h0);
        checkOutput("wr mem_addr", 32'(bus.mem_addr), 32'h5);
        checkOutput("wr mem_wdata", 32'(bus.mem_wdata), 32'h2A5);

        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput("rd mem_re", 32'(bus.mem_re), 32'h1);
        checkOutput("rd mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("rd mem_addr", 32'(bus.mem_addr), 32'h5);

        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rd rvalid", 32'(bus.rvalid), 32'h1);
        checkOutput("rd rdata", 32'(bus.rdata), 32'h2A5);
        checkOutput("idle mem_re", 32'(bus.mem_re), 32'h0);
        checkOutput("idle mem_addr hold", 32'(bus.mem_addr), 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
